// File: rtl/led_fade_engine.sv
// Multi-channel PWM LED fader: one shared PWM counter, per-channel level and fade FSM.
// Optional LED_FADE_GAMMA_EN: squared-level comparison via one time-multiplexed multiplier.
module led_fade_engine #(
    parameter int CHANNELS    = 4,
    parameter int PWM_BITS    = 8,
    parameter int PERIOD_BITS = 3
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   io_cmd_valid,
    output logic                   io_cmd_ready,
    input  logic [3:0]             io_cmd_chan,
    input  logic [1:0]             io_cmd_op,
    input  logic [PERIOD_BITS-1:0] io_cmd_period,
    output logic [CHANNELS-1:0]    io_out,
    output logic [CHANNELS-1:0]    io_busy,
    output logic [CHANNELS-1:0]    io_done
);

    localparam int DIV_BITS = (1 << PERIOD_BITS) - 1;
    localparam logic [PWM_BITS-1:0] MAX = '1;

    localparam logic [1:0] OP_SET_OFF  = 2'd0;
    localparam logic [1:0] OP_SET_ON   = 2'd1;
    localparam logic [1:0] OP_FADE_IN  = 2'd2;

    typedef enum logic [1:0] {ST_OFF, ST_FADE_IN, ST_ON, ST_FADE_OUT} fade_state_t;

    logic [PWM_BITS-1:0]    counter;
    logic                   frame_end;

    logic                   cmd_pending;
    logic [3:0]             cmd_chan;
    logic [1:0]             cmd_op;
    logic [PERIOD_BITS-1:0] cmd_period;

    fade_state_t            state_q [CHANNELS];
    fade_state_t            state_d [CHANNELS];
    logic [PWM_BITS-1:0]    level_q [CHANNELS];
    logic [PWM_BITS-1:0]    level_d [CHANNELS];
    logic [DIV_BITS-1:0]    div_q   [CHANNELS];
    logic [DIV_BITS-1:0]    div_d   [CHANNELS];
    logic [PERIOD_BITS-1:0] per_q   [CHANNELS];
    logic [PERIOD_BITS-1:0] per_d   [CHANNELS];
    logic [CHANNELS-1:0]    done_q;
    logic [CHANNELS-1:0]    done_d;

    function automatic logic [DIV_BITS-1:0] step_limit(input logic [PERIOD_BITS-1:0] p);
        logic [DIV_BITS:0] span;
        span = ({{DIV_BITS{1'b0}}, 1'b1} << p) - 1'b1;
        return span[DIV_BITS-1:0];
    endfunction

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            counter <= '0;
        end else begin
            counter <= counter + 1'b1;
        end
    end

    assign frame_end = (counter == MAX);

    // A command is held for exactly one cycle, which is what drops ready for that cycle.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cmd_pending <= 1'b0;
            cmd_chan    <= '0;
            cmd_op      <= '0;
            cmd_period  <= '0;
        end else if (io_cmd_valid && !cmd_pending) begin
            cmd_pending <= 1'b1;
            cmd_chan    <= io_cmd_chan;
            cmd_op      <= io_cmd_op;
            cmd_period  <= io_cmd_period;
        end else begin
            cmd_pending <= 1'b0;
        end
    end

    assign io_cmd_ready = !cmd_pending;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < CHANNELS; i++) begin
                state_q[i] <= ST_OFF;
                level_q[i] <= '0;
                div_q[i]   <= '0;
                per_q[i]   <= '0;
            end
            done_q <= '0;
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                state_q[i] <= state_d[i];
                level_q[i] <= level_d[i];
                div_q[i]   <= div_d[i];
                per_q[i]   <= per_d[i];
            end
            done_q <= done_d;
        end
    end

    // An applied command takes priority over a fade step in the same cycle.
    always_comb begin
        done_d = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            state_d[i] = state_q[i];
            level_d[i] = level_q[i];
            div_d[i]   = div_q[i];
            per_d[i]   = per_q[i];
            if (cmd_pending && cmd_chan == 4'(i)) begin
                case (cmd_op)
                    OP_SET_OFF: begin
                        level_d[i] = '0;
                        state_d[i] = ST_OFF;
                    end
                    OP_SET_ON: begin
                        level_d[i] = MAX;
                        state_d[i] = ST_ON;
                    end
                    OP_FADE_IN: begin
                        per_d[i] = cmd_period;
                        div_d[i] = '0;
                        if (level_q[i] == MAX) begin
                            state_d[i] = ST_ON;
                            done_d[i]  = 1'b1;
                        end else begin
                            state_d[i] = ST_FADE_IN;
                        end
                    end
                    default: begin
                        per_d[i] = cmd_period;
                        div_d[i] = '0;
                        if (level_q[i] == '0) begin
                            state_d[i] = ST_OFF;
                            done_d[i]  = 1'b1;
                        end else begin
                            state_d[i] = ST_FADE_OUT;
                        end
                    end
                endcase
            end else if (frame_end && (state_q[i] == ST_FADE_IN || state_q[i] == ST_FADE_OUT)) begin
                if (div_q[i] == step_limit(per_q[i])) begin
                    div_d[i] = '0;
                    if (state_q[i] == ST_FADE_IN) begin
                        if (level_q[i] != MAX) begin
                            level_d[i] = level_q[i] + 1'b1;
                        end
                        if (level_d[i] == MAX) begin
                            state_d[i] = ST_ON;
                            done_d[i]  = 1'b1;
                        end
                    end else begin
                        if (level_q[i] != '0) begin
                            level_d[i] = level_q[i] - 1'b1;
                        end
                        if (level_d[i] == '0) begin
                            state_d[i] = ST_OFF;
                            done_d[i]  = 1'b1;
                        end
                    end
                end else begin
                    div_d[i] = div_q[i] + 1'b1;
                end
            end
        end
    end

`ifdef LED_FADE_GAMMA_EN
    localparam int SEL_BITS = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    logic [SEL_BITS-1:0]     gamma_sel;
    logic [2*PWM_BITS-1:0]   square;
    logic [PWM_BITS-1:0]     eff_q [CHANNELS];

    assign square = level_q[gamma_sel] * level_q[gamma_sel];

    // One channel's effective level is refreshed per cycle, round-robin.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            gamma_sel <= '0;
            for (int i = 0; i < CHANNELS; i++) begin
                eff_q[i] <= '0;
            end
        end else begin
            eff_q[gamma_sel] <= (level_q[gamma_sel] == MAX) ? MAX : square[2*PWM_BITS-1:PWM_BITS];
            gamma_sel <= (gamma_sel == SEL_BITS'(CHANNELS - 1)) ? '0 : gamma_sel + 1'b1;
        end
    end

    always_comb begin
        io_out  = '0;
        io_busy = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            io_out[i]  = (level_q[i] == MAX) || (counter < eff_q[i]);
            io_busy[i] = (state_q[i] == ST_FADE_IN) || (state_q[i] == ST_FADE_OUT);
        end
    end
`else
    always_comb begin
        io_out  = '0;
        io_busy = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            io_out[i]  = (level_q[i] == MAX) || (counter < level_q[i]);
            io_busy[i] = (state_q[i] == ST_FADE_IN) || (state_q[i] == ST_FADE_OUT);
        end
    end
`endif

    assign io_done = done_q;

endmodule
